// File: rtl/timer_period_capture_if.sv
// Measured-period output stream: one period per valid/ready transfer.
interface timer_period_capture_if #(
  parameter int CNT_W = 32
);
  logic             period_valid;
  logic             period_ready;
  logic [CNT_W-1:0] period_data;

  modport master (output period_valid, output period_data, input period_ready);
  modport slave  (input period_valid, input period_data, output period_ready);
endinterface

// File: rtl/timer_period_capture.sv
// Rising-edge period meter: edge detect, measurement FSM with saturating
// counter and timeout, and a small FIFO of captured periods.
module timer_period_capture #(
  parameter int CNT_W       = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pulse_in,
  input  logic                          enable,
  input  logic [CNT_W-1:0]              timeout_val,
  input  logic                          clear_flags,
  timer_period_capture_if.master        period,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_flag,
  output logic                          overflow_flag
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             s, s_prev, pulse_edge;
  logic             cap, to_hit;
  logic             fifo_empty, fifo_full, pop, push_ok, ovf_hit;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0] mem [FIFO_DEPTH];

  // Optional synchronizer chain for pulse trains from another clock domain.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = pulse_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (!rst) sync_q <= '0;
        else begin
          sync_q[0] <= pulse_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) s_prev <= 1'b0;
    else      s_prev <= s;
  end

  assign pulse_edge = s & ~s_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // An edge always beats a coincident timeout; the counter sticks at all-ones.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    to_hit  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n   = '0;
          state_n = ARMED;
        end
        ARMED: begin
          if (pulse_edge) begin
            cnt_n   = CNT_ONE;
            state_n = MEASURE;
          end
        end
        MEASURE: begin
          if (pulse_edge) begin
            cap   = 1'b1;
            cnt_n = CNT_ONE;
          end else if (timeout_val != '0 && cnt == timeout_val) begin
            to_hit  = 1'b1;
            cnt_n   = '0;
            state_n = ARMED;
          end else if (cnt != '1) begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_CNT);
  assign pop        = ~fifo_empty & period.period_ready;
  // A full FIFO still takes a capture when the head leaves in the same cycle.
  assign push_ok    = cap & (~fifo_full | pop);
  assign ovf_hit    = cap & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst && push_ok) mem[wr_ptr] <= cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_flag  <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      timeout_flag  <= to_hit  | (timeout_flag  & ~clear_flags);
      overflow_flag <= ovf_hit | (overflow_flag & ~clear_flags);
    end
  end

  assign period.period_valid = ~fifo_empty;
  assign period.period_data  = fifo_empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_timer_period_capture.sv
// Bench for timer_period_capture: 32-bit and 4-bit instances share stimulus and
// are compared against a timestamp/queue reference model plus directed checks.
module tb_timer_period_capture;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst, pulse_in, enable, clear_flags, ready;
  logic [31:0] timeout_val;
  logic [2:0]  cnt0, cnt1;
  logic        tf0, of0, tf1, of1;

  always #5 clk = ~clk;

  timer_period_capture_if #(.CNT_W(32)) p0 ();
  timer_period_capture_if #(.CNT_W(4))  p1 ();
  assign p0.period_ready = ready;
  assign p1.period_ready = ready;

  timer_period_capture #(.CNT_W(32), .FIFO_DEPTH(FD), .SYNC_STAGES(0)) u0 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .enable(enable),
    .timeout_val(timeout_val), .clear_flags(clear_flags), .period(p0),
    .fifo_count(cnt0), .timeout_flag(tf0), .overflow_flag(of0));

  timer_period_capture #(.CNT_W(4), .FIFO_DEPTH(FD), .SYNC_STAGES(0)) u1 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .enable(enable),
    .timeout_val(timeout_val[3:0]), .clear_flags(clear_flags), .period(p1),
    .fifo_count(cnt1), .timeout_flag(tf1), .overflow_flag(of1));

  // Reference model: a period is the distance between edge timestamps.
  longint unsigned mq [2][FD];
  int              msz [2];
  bit              act [2], have [2], mtf [2], mof [2];
  longint unsigned mref [2];
  bit              prev_p;
  longint unsigned t;
  int              vecs, fails;

  task automatic model_update();
    bit e, pop, push, tset, oset;
    longint unsigned tv, v, el, lim;
    if (!rst) begin
      prev_p = 1'b0;
      for (int k = 0; k < 2; k++) begin
        act[k] = 0; have[k] = 0; msz[k] = 0; mtf[k] = 0; mof[k] = 0;
      end
    end else begin
      e = pulse_in && !prev_p;
      prev_p = pulse_in;
      for (int k = 0; k < 2; k++) begin
        tv   = (k == 0) ? 64'(timeout_val) : 64'(timeout_val[3:0]);
        lim  = (k == 0) ? 64'hFFFF_FFFF : 64'd15;
        push = 0; tset = 0; v = 0;
        pop  = (msz[k] != 0) && ready;
        if (!enable) begin
          act[k] = 0; have[k] = 0;
        end else if (!act[k]) begin
          act[k] = 1;
        end else if (!have[k]) begin
          if (e) begin have[k] = 1; mref[k] = t; end
        end else begin
          el = t - mref[k];
          if (e) begin
            push = 1; v = (el > lim) ? lim : el; mref[k] = t;
          end else if (tv != 0 && el == tv) begin
            tset = 1; have[k] = 0;
          end
        end
        oset = push && (msz[k] == FD) && !pop;
        if (pop) begin
          for (int i = 0; i < FD - 1; i++) mq[k][i] = mq[k][i+1];
          msz[k]--;
        end
        if (push && !oset) begin mq[k][msz[k]] = v; msz[k]++; end
        mtf[k] = tset || (mtf[k] && !clear_flags);
        mof[k] = oset || (mof[k] && !clear_flags);
      end
    end
    t++;
  endtask

  function automatic logic [37:0] exp_vec(int k);
    logic [31:0] d;
    d = (msz[k] != 0) ? 32'(mq[k][0]) : 32'd0;
    return {msz[k] != 0, 3'(msz[k]), mtf[k], mof[k], d};
  endfunction

  // Observed outputs; data is only meaningful while valid.
  function automatic logic [37:0] obs(int k);
    if (k == 0)
      return {p0.period_valid, cnt0, tf0, of0, p0.period_valid ? p0.period_data : 32'd0};
    return {p1.period_valid, cnt1, tf1, of1, 28'd0, p1.period_valid ? p1.period_data : 4'd0};
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; pulse_in = 1'b0; clear_flags = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int gaps [2] = '{4, 4};
    rst = 1'b0; enable = 1'b0; ready = 1'b0; pulse_in = 1'b0;
    timeout_val = 32'd0; clear_flags = 1'b0;
    tick(); tick();
    vecs++; if ({p0.period_valid, cnt0, tf0, of0, p0.period_data} !== 38'd0) begin
      fails++; $display("FAIL reset_init0: got %h expected 0", {p0.period_valid, cnt0, tf0, of0, p0.period_data}); end
    vecs++; if ({p1.period_valid, cnt1, tf1, of1, p1.period_data} !== 10'd0) begin
      fails++; $display("FAIL reset_init1: got %h expected 0", {p1.period_valid, cnt1, tf1, of1, p1.period_data}); end
    rst = 1'b1; enable = 1'b1;
    tick();
    foreach (gaps[g])
      for (int c = 0; c < gaps[g]; c++) begin
        pulse_in = (c == 0); tick();
        vecs++; if (obs(0) !== exp_vec(0)) begin
          fails++; $display("FAIL reset_fill: got %h expected %h", obs(0), exp_vec(0)); end
      end
    pulse_in = 1'b1; tick();
    pulse_in = 1'b0; timeout_val = 32'd3;
    repeat (4) tick();
    vecs++; if ({cnt0, tf0} !== {3'd2, 1'b1}) begin
      fails++; $display("FAIL reset_pre: got cnt=%0d tf=%0b expected cnt=2 tf=1", cnt0, tf0); end
    timeout_val = 32'd0;
    pulse_in = 1'b1; tick();
    pulse_in = 1'b0; tick(); tick();
    rst = 1'b0; tick(); rst = 1'b1;
    vecs++; if ({p0.period_valid, cnt0, tf0, of0, p0.period_data} !== 38'd0) begin
      fails++; $display("FAIL reset_mid: got %h expected 0", {p0.period_valid, cnt0, tf0, of0, p0.period_data}); end
    for (int c = 0; c < 8; c++) begin
      pulse_in = (c == 2); tick();
      vecs++; if (cnt0 !== 3'd0 || obs(0) !== exp_vec(0)) begin
        fails++; $display("FAIL reset_arm_only: got %h expected %h", obs(0), exp_vec(0)); end
    end
  endtask

  task automatic test_nominal();
    logic ev;
    do_reset();
    enable = 1'b1; ready = 1'b1; timeout_val = 32'd0;
    for (int c = 0; c < 40; c++) begin
      pulse_in = (c % 5 == 1); tick();
      ev = (c >= 6) && (c % 5 == 1);
      vecs++; if ({p0.period_valid, obs(0)} !== {ev, ev, 3'(ev), 2'b00, ev ? 32'd5 : 32'd0}) begin
        fails++; $display("FAIL nominal c=%0d: got v=%0b d=%0d expected v=%0b d=5", c, p0.period_valid, p0.period_data, ev); end
      vecs++; if (obs(1) !== exp_vec(1)) begin
        fails++; $display("FAIL nominal_w4: got %h expected %h", obs(1), exp_vec(1)); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    enable = 1'b1; ready = 1'b0; timeout_val = 32'd0;
    for (int c = 0; c < 38; c++) begin
      pulse_in = (c % 7 == 1); tick();
      vecs++; if (obs(0) !== exp_vec(0)) begin
        fails++; $display("FAIL overflow_fill: got %h expected %h", obs(0), exp_vec(0)); end
    end
    vecs++; if ({cnt0, of0} !== {3'd4, 1'b1}) begin
      fails++; $display("FAIL overflow_full: got cnt=%0d of=%0b expected cnt=4 of=1", cnt0, of0); end
    pulse_in = 1'b0; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vecs++; if ({p0.period_valid, p0.period_data} !== {1'b1, 32'd7}) begin
        fails++; $display("FAIL overflow_drain%0d: got v=%0b d=%0d expected v=1 d=7", i, p0.period_valid, p0.period_data); end
      tick();
    end
    vecs++; if (p0.period_valid !== 1'b0) begin
      fails++; $display("FAIL overflow_empty: got v=%0b expected 0", p0.period_valid); end
  endtask

  task automatic test_full_pop();
    int gaps [5] = '{3, 4, 5, 6, 7};
    do_reset();
    enable = 1'b1; ready = 1'b0; timeout_val = 32'd0;
    tick();
    foreach (gaps[g])
      for (int c = 0; c < gaps[g]; c++) begin
        pulse_in = (c == 0); tick();
        vecs++; if (obs(0) !== exp_vec(0)) begin
          fails++; $display("FAIL full_pop_fill: got %h expected %h", obs(0), exp_vec(0)); end
      end
    pulse_in = 1'b1; ready = 1'b1; tick();
    pulse_in = 1'b0;
    vecs++; if ({cnt0, of0} !== {3'd4, 1'b0}) begin
      fails++; $display("FAIL full_pop_count: got cnt=%0d of=%0b expected cnt=4 of=0", cnt0, of0); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if ({p0.period_valid, p0.period_data} !== {1'b1, 32'(4 + i)}) begin
        fails++; $display("FAIL full_pop_order%0d: got v=%0b d=%0d expected d=%0d", i, p0.period_valid, p0.period_data, 4 + i); end
      tick();
    end
    vecs++; if (p0.period_valid !== 1'b0) begin
      fails++; $display("FAIL full_pop_empty: got v=%0b expected 0", p0.period_valid); end
  endtask

  task automatic test_timeout();
    do_reset();
    enable = 1'b1; ready = 1'b1; timeout_val = 32'd10;
    tick();
    pulse_in = 1'b1; tick();
    pulse_in = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      vecs++; if ({tf0, cnt0} !== {j >= 10, 3'd0}) begin
        fails++; $display("FAIL timeout_j%0d: got tf=%0b cnt=%0d expected tf=%0b cnt=0", j, tf0, cnt0, j >= 10); end
      vecs++; if (obs(1) !== exp_vec(1)) begin
        fails++; $display("FAIL timeout_w4: got %h expected %h", obs(1), exp_vec(1)); end
    end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    vecs++; if (tf0 !== 1'b0) begin
      fails++; $display("FAIL timeout_clear: got tf=%0b expected 0", tf0); end
    pulse_in = 1'b1; tick();
    pulse_in = 1'b0; tick(); tick();
    pulse_in = 1'b1; tick();
    vecs++; if ({p0.period_valid, p0.period_data} !== {1'b1, 32'd3}) begin
      fails++; $display("FAIL timeout_rearm: got v=%0b d=%0d expected v=1 d=3", p0.period_valid, p0.period_data); end
    pulse_in = 1'b0; tick(); tick();
    pulse_in = 1'b1; tick();
    pulse_in = 1'b0;
    repeat (9) tick();
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    vecs++; if (tf0 !== 1'b1) begin
      fails++; $display("FAIL timeout_set_wins: got tf=%0b expected 1", tf0); end
    tick();
    vecs++; if (obs(0) !== exp_vec(0) || tf0 !== 1'b1) begin
      fails++; $display("FAIL timeout_sticky: got %h expected %h", obs(0), exp_vec(0)); end
  endtask

  task automatic test_enable_sat();
    do_reset();
    enable = 1'b1; ready = 1'b0; timeout_val = 32'd0;
    tick();
    pulse_in = 1'b1; tick();
    pulse_in = 1'b0;
    repeat (19) tick();
    pulse_in = 1'b1; tick();
    pulse_in = 1'b0;
    vecs++; if ({p0.period_valid, p0.period_data} !== {1'b1, 32'd20}) begin
      fails++; $display("FAIL sat_w32: got v=%0b d=%0d expected v=1 d=20", p0.period_valid, p0.period_data); end
    vecs++; if ({p1.period_valid, p1.period_data} !== {1'b1, 4'd15}) begin
      fails++; $display("FAIL sat_w4: got v=%0b d=%0d expected v=1 d=15", p1.period_valid, p1.period_data); end
    repeat (5) tick();
    enable = 1'b0; tick();
    enable = 1'b1; pulse_in = 1'b1; tick();
    pulse_in = 1'b0; tick();
    vecs++; if (cnt0 !== 3'd1) begin
      fails++; $display("FAIL en_drop_nopush: got cnt=%0d expected 1", cnt0); end
    pulse_in = 1'b1; tick();
    vecs++; if (cnt0 !== 3'd1) begin
      fails++; $display("FAIL en_rearm: got cnt=%0d expected 1", cnt0); end
    pulse_in = 1'b0; repeat (3) tick();
    pulse_in = 1'b1; tick();
    pulse_in = 1'b0;
    vecs++; if ({cnt0, p0.period_data} !== {3'd2, 32'd20}) begin
      fails++; $display("FAIL en_retain: got cnt=%0d d=%0d expected cnt=2 d=20", cnt0, p0.period_data); end
    vecs++; if (obs(1) !== exp_vec(1)) begin
      fails++; $display("FAIL en_w4: got %h expected %h", obs(1), exp_vec(1)); end
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      if (c % 100 == 0)
        timeout_val = ((c / 100) % 2 == 1) ? 32'd0 : 32'($urandom_range(3, 12));
      pulse_in    = (c < 600) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      ready       = ($urandom_range(0, 2) != 0);
      enable      = ($urandom_range(0, 39) != 0);
      clear_flags = ($urandom_range(0, 29) == 0);
      tick();
      vecs++; if (obs(0) !== exp_vec(0)) begin
        fails++; $display("FAIL random_w32 c=%0d: got %h expected %h", c, obs(0), exp_vec(0)); end
      vecs++; if (obs(1) !== exp_vec(1)) begin
        fails++; $display("FAIL random_w4 c=%0d: got %h expected %h", c, obs(1), exp_vec(1)); end
    end
    clear_flags = 1'b0;
  endtask

  initial begin
    vecs = 0; fails = 0; t = 0; prev_p = 1'b0;
    test_reset();
    test_nominal();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_enable_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
